// File: rtl/rc4_crack_pkg.sv
// Shared definitions for the RC4 key-search datapath: key sizing, dispatcher
// state encoding and a small bit-count helper.
package rc4_crack_pkg;

    localparam int KEY_WIDTH = 24;
    localparam logic [KEY_WIDTH-1:0] KEY_MAX = 24'h3FFFFF;

    typedef logic [KEY_WIDTH-1:0] key_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } dispatch_state_t;

    // Sized for the largest supported core array (16).
    function automatic logic [4:0] count_ones(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'b0000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/key_dispatcher_first_one_picker.sv
// Combinational lowest-set-bit finder: returns the index of the lowest
// asserted request and whether any request is asserted at all.
module first_one_picker #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // Scanning downward lets the lowest set bit overwrite higher ones.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IW'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_dispatcher.sv
// Hands out RC4 keys in ascending order to a pool of crack cores, gathers
// their verdicts and stops the search on the first reported valid key.
module key_dispatcher #(
    parameter int NUM_CORES = 4,
    parameter int KEY_WIDTH = rc4_crack_pkg::KEY_WIDTH,
    parameter logic [KEY_WIDTH-1:0] KEY_MAX = rc4_crack_pkg::KEY_MAX
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    output logic [NUM_CORES-1:0]           core_start,
    output logic [NUM_CORES*KEY_WIDTH-1:0] core_key,
    input  logic [NUM_CORES-1:0]           core_finish,
    input  logic [NUM_CORES-1:0]           core_found,
    output logic                           busy,
    output logic                           finish,
    output logic                           found,
    output logic [KEY_WIDTH-1:0]           found_key,
    output logic [KEY_WIDTH:0]             keys_tried
);

    import rc4_crack_pkg::*;

    localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    // One extra bit so an all-ones KEY_MAX still terminates.
    localparam logic [KEY_WIDTH:0] KEY_LIMIT = {1'b0, KEY_MAX};

    dispatch_state_t        state_q, state_d;
    logic [KEY_WIDTH:0]     next_key_q, next_key_d;
    logic [NUM_CORES-1:0]   core_busy_q, core_busy_d;
    logic [NUM_CORES-1:0]   core_start_q, core_start_d;
    logic [KEY_WIDTH-1:0]   core_key_q [NUM_CORES];
    logic [KEY_WIDTH-1:0]   core_key_d [NUM_CORES];
    logic                   found_q, found_d;
    logic [KEY_WIDTH-1:0]   found_key_q, found_key_d;
    logic [KEY_WIDTH:0]     keys_tried_q, keys_tried_d;

    logic [NUM_CORES-1:0]   fin_vec;
    logic [NUM_CORES-1:0]   hit_vec;
    logic [NUM_CORES-1:0]   free_vec;
    logic [IW-1:0]          free_idx;
    logic                   free_valid;
    logic [IW-1:0]          hit_idx;
    logic                   hit_valid;
    logic                   hit_take;
    logic                   keys_left;
    logic                   can_dispatch;

    // Finishes from cores we never started are dropped here.
    assign fin_vec  = core_finish & core_busy_q & {NUM_CORES{state_q != IDLE}};
    assign hit_vec  = fin_vec & core_found;
    assign free_vec = ~core_busy_q | fin_vec;

    first_one_picker #(.N(NUM_CORES)) u_free_pick (
        .req   (free_vec),
        .idx   (free_idx),
        .valid (free_valid)
    );

    first_one_picker #(.N(NUM_CORES)) u_hit_pick (
        .req   (hit_vec),
        .idx   (hit_idx),
        .valid (hit_valid)
    );

    assign hit_take     = hit_valid && !found_q && (state_q == RUN || state_q == DRAIN);
    assign keys_left    = (next_key_q <= KEY_LIMIT);
    assign can_dispatch = (state_q == RUN) && !hit_take && keys_left && free_valid;

    always_comb begin
        state_d      = state_q;
        next_key_d   = next_key_q;
        core_busy_d  = core_busy_q & ~fin_vec;
        core_start_d = '0;
        found_d      = found_q;
        found_key_d  = found_key_q;
        keys_tried_d = keys_tried_q + (KEY_WIDTH + 1)'(count_ones(16'(fin_vec)));

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d      = RUN;
                    next_key_d   = '0;
                    found_d      = 1'b0;
                    found_key_d  = '0;
                    keys_tried_d = '0;
                end
            end
            RUN: begin
                if (hit_take || !keys_left) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (core_busy_q == '0) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (hit_take) begin
            found_d     = 1'b1;
            found_key_d = core_key_q[hit_idx];
        end

        // A core finishing this cycle may be handed its next key at once.
        if (can_dispatch) begin
            core_start_d[free_idx] = 1'b1;
            core_busy_d[free_idx]  = 1'b1;
            next_key_d             = next_key_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            next_key_q   <= '0;
            core_busy_q  <= '0;
            core_start_q <= '0;
            found_q      <= 1'b0;
            found_key_q  <= '0;
            keys_tried_q <= '0;
        end else begin
            state_q      <= state_d;
            next_key_q   <= next_key_d;
            core_busy_q  <= core_busy_d;
            core_start_q <= core_start_d;
            found_q      <= found_d;
            found_key_q  <= found_key_d;
            keys_tried_q <= keys_tried_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CORES; gi++) begin : g_core
            assign core_key_d[gi] = core_start_d[gi] ? next_key_q[KEY_WIDTH-1:0] : core_key_q[gi];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    core_key_q[gi] <= '0;
                end else begin
                    core_key_q[gi] <= core_key_d[gi];
                end
            end

            assign core_key[gi*KEY_WIDTH +: KEY_WIDTH] = core_key_q[gi];
        end
    endgenerate

    assign core_start = core_start_q;
    assign busy       = (state_q == RUN) || (state_q == DRAIN);
    assign finish     = (state_q == DONE);
    assign found      = found_q;
    assign found_key  = found_key_q;
    assign keys_tried = keys_tried_q;

endmodule

// File: tb/tb_key_dispatcher.sv
// Bench for key_dispatcher: behavioural crack cores (or hand-driven finishes)
// against a scoreboard of the keys expected to be issued, in ascending order.
module tb_key_dispatcher;

    localparam int NC   = 4;
    localparam int KW   = 24;
    localparam int KMAX = 15;
    localparam logic [KW:0] NO_HIT = 25'h1FFFFFF;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [NC-1:0]   core_start;
    logic [NC*KW-1:0] core_key;
    logic [NC-1:0]   core_finish;
    logic [NC-1:0]   core_found;
    logic            busy;
    logic            finish;
    logic            found;
    logic [KW-1:0]   found_key;
    logic [KW:0]     keys_tried;

    logic            auto_mode;
    logic [NC-1:0]   model_finish, model_found;
    logic [NC-1:0]   man_finish, man_found;
    logic            model_flush;
    int              lat [NC];
    logic [KW:0]     hit_a, hit_b;

    logic [NC-1:0]   m_active;
    int              m_cnt [NC];
    logic [KW-1:0]   m_key [NC];
    int              m_dbl;

    int              cyc;
    int              obs_key [$];
    int              obs_core [$];
    int              obs_cyc [$];

    int              exp_q [$];
    int              rd_idx;
    int              base;
    int              base_dbl;
    int              checks;
    int              failures;

    assign core_finish = auto_mode ? model_finish : man_finish;
    assign core_found  = auto_mode ? model_found  : man_found;

    always #5 clk = ~clk;

    key_dispatcher #(.NUM_CORES(NC), .KEY_WIDTH(KW), .KEY_MAX(24'h00000F)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .core_start  (core_start),
        .core_key    (core_key),
        .core_finish (core_finish),
        .core_found  (core_found),
        .busy        (busy),
        .finish      (finish),
        .found       (found),
        .found_key   (found_key),
        .keys_tried  (keys_tried)
    );

    // Issue log: every core_start pulse with its key, core and cycle.
    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            for (int i = 0; i < NC; i++) begin
                if (core_start[i]) begin
                    obs_key.push_back(int'(core_key[i*KW +: KW]));
                    obs_core.push_back(i);
                    obs_cyc.push_back(cyc);
                end
            end
        end
    end

    // Behavioural crack cores: finish lat[i] cycles after start, found on hit keys.
    initial begin
        m_active     = '0;
        m_dbl        = 0;
        model_finish = '0;
        model_found  = '0;
        forever begin
            @(negedge clk);
            model_finish = '0;
            model_found  = '0;
            if (reset || model_flush) begin
                m_active = '0;
            end else begin
                for (int i = 0; i < NC; i++) begin
                    if (m_active[i]) begin
                        m_cnt[i] = m_cnt[i] - 1;
                        if (m_cnt[i] == 0) begin
                            model_finish[i] = 1'b1;
                            model_found[i]  = ({1'b0, m_key[i]} == hit_a) || ({1'b0, m_key[i]} == hit_b);
                            m_active[i]     = 1'b0;
                        end
                    end
                    if (core_start[i]) begin
                        if (m_active[i] && auto_mode) m_dbl++;
                        m_active[i] = 1'b1;
                        m_cnt[i]    = lat[i];
                        m_key[i]    = core_key[i*KW +: KW];
                    end
                end
            end
        end
    end

    task automatic begin_run();
        @(posedge clk) model_flush = 1'b1;
        @(posedge clk) model_flush = 1'b0;
        exp_q.delete();
        for (int k = 0; k <= KMAX; k++) exp_q.push_back(k);
        rd_idx   = obs_key.size();
        base     = rd_idx;
        base_dbl = m_dbl;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic man_pulse(input logic [NC-1:0] fin, input logic [NC-1:0] fnd);
        @(negedge clk);
        man_finish = fin;
        man_found  = fnd;
        @(negedge clk);
        man_finish = '0;
        man_found  = '0;
    endtask

    task automatic wait_issued(input int n);
        for (int c = 0; c < 500; c++) begin
            if (obs_key.size() >= base + n) break;
            @(negedge clk);
        end
    endtask

    task automatic wait_done();
        for (int c = 0; c < 3000; c++) begin
            if (finish === 1'b1) break;
            @(negedge clk);
        end
        checks++;
        if (finish !== 1'b1) begin
            failures++;
            $display("FAIL done_timeout: finish=%b required 1", finish);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks += 7;
        if (core_start !== '0) begin failures++; $display("FAIL rst_core_start: got %h required 0", core_start); end
        if (core_key !== '0)   begin failures++; $display("FAIL rst_core_key: got %h required 0", core_key); end
        if (busy !== 1'b0)     begin failures++; $display("FAIL rst_busy: got %b required 0", busy); end
        if (finish !== 1'b0)   begin failures++; $display("FAIL rst_finish: got %b required 0", finish); end
        if (found !== 1'b0)    begin failures++; $display("FAIL rst_found: got %b required 0", found); end
        if (found_key !== '0)  begin failures++; $display("FAIL rst_found_key: got %h required 0", found_key); end
        if (keys_tried !== '0) begin failures++; $display("FAIL rst_keys_tried: got %0d required 0", keys_tried); end
        $display("test_reset: outputs checked under reset");
        @(negedge clk) reset = 1'b0;
    endtask

    task automatic test_first_hit();
        auto_mode = 1'b1;
        for (int i = 0; i < NC; i++) lat[i] = 10;
        hit_a = 25'd7;
        hit_b = NO_HIT;
        begin_run();
        wait_done();
        while (rd_idx < obs_key.size()) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++; $display("FAIL hit_sb_key: issued %0d with nothing expected", obs_key[rd_idx]);
            end else begin
                if (obs_key[rd_idx] !== exp_q[0]) begin failures++; $display("FAIL hit_sb_key: issued %0d required %0d", obs_key[rd_idx], exp_q[0]); end
                void'(exp_q.pop_front());
            end
            rd_idx++;
        end
        checks++;
        if (obs_key.size() < base + 4) begin
            failures++; $display("FAIL hit_first4: only %0d keys issued", obs_key.size() - base);
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (obs_core[base+k] !== k || obs_cyc[base+k] !== obs_cyc[base] + k) begin
                    failures++; $display("FAIL hit_first4: start %0d core %0d cycle %0d required core %0d cycle %0d", k, obs_core[base+k], obs_cyc[base+k], k, obs_cyc[base] + k);
                end
            end
        end
        checks += 6;
        if (found !== 1'b1)           begin failures++; $display("FAIL hit_found: got %b required 1", found); end
        if (found_key !== 24'd7)      begin failures++; $display("FAIL hit_found_key: got %0d required 7", found_key); end
        if (keys_tried !== 25'd11)    begin failures++; $display("FAIL hit_keys_tried: got %0d required 11", keys_tried); end
        if (obs_key.size() - base != 11) begin failures++; $display("FAIL hit_issued: got %0d required 11", obs_key.size() - base); end
        if (m_active !== '0)          begin failures++; $display("FAIL hit_drain: cores still active %b at finish", m_active); end
        if (m_dbl != base_dbl)        begin failures++; $display("FAIL hit_double_start: %0d starts to busy cores", m_dbl - base_dbl); end
        $display("test_first_hit: found=%b found_key=%0d keys_tried=%0d issued=%0d", found, found_key, keys_tried, obs_key.size() - base);
    endtask

    task automatic test_exhaust_and_restarts();
        for (int i = 0; i < NC; i++) lat[i] = 6;
        hit_a = NO_HIT;
        hit_b = NO_HIT;
        begin_run();
        checks += 4;
        if (found !== 1'b0)    begin failures++; $display("FAIL rerun_found_clr: got %b required 0", found); end
        if (keys_tried !== '0) begin failures++; $display("FAIL rerun_tried_clr: got %0d required 0", keys_tried); end
        if (finish !== 1'b0)   begin failures++; $display("FAIL rerun_finish_clr: got %b required 0", finish); end
        if (busy !== 1'b1)     begin failures++; $display("FAIL rerun_busy: got %b required 1", busy); end
        wait_issued(6);
        pulse_start();
        wait_issued(16);
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || finish !== 1'b0) begin failures++; $display("FAIL drain_state: busy=%b finish=%b required 1/0", busy, finish); end
        pulse_start();
        wait_done();
        repeat (5) @(negedge clk);
        while (rd_idx < obs_key.size()) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++; $display("FAIL exh_sb_key: issued %0d with nothing expected", obs_key[rd_idx]);
            end else begin
                if (obs_key[rd_idx] !== exp_q[0]) begin failures++; $display("FAIL exh_sb_key: issued %0d required %0d", obs_key[rd_idx], exp_q[0]); end
                void'(exp_q.pop_front());
            end
            rd_idx++;
        end
        checks += 6;
        if (exp_q.size() != 0)        begin failures++; $display("FAIL exh_unissued: %0d keys never issued", exp_q.size()); end
        if (keys_tried !== 25'd16)    begin failures++; $display("FAIL exh_keys_tried: got %0d required 16", keys_tried); end
        if (found !== 1'b0)           begin failures++; $display("FAIL exh_found: got %b required 0", found); end
        if (found_key !== '0)         begin failures++; $display("FAIL exh_found_key: got %h required 0", found_key); end
        if (finish !== 1'b1)          begin failures++; $display("FAIL exh_finish_hold: got %b required 1", finish); end
        if (m_dbl != base_dbl)        begin failures++; $display("FAIL exh_double_start: %0d starts to busy cores", m_dbl - base_dbl); end
        $display("test_exhaust_and_restarts: issued=%0d keys_tried=%0d found=%b", obs_key.size() - base, keys_tried, found);
    endtask

    task automatic test_same_cycle_hits();
        @(negedge clk) auto_mode = 1'b0;
        begin_run();
        wait_issued(4);
        for (int k = 0; k < NC; k++) begin
            man_pulse(NC'(1 << k), '0);
            checks++;
            if (core_start !== NC'(1 << k) || core_key[k*KW +: KW] !== KW'(4 + k)) begin
                failures++; $display("FAIL sch_redispatch%0d: core_start=%b key=%0d required %b key %0d", k, core_start, core_key[k*KW +: KW], NC'(1 << k), 4 + k);
            end
        end
        man_pulse(4'b1010, 4'b1010);
        checks += 3;
        if (found !== 1'b1)        begin failures++; $display("FAIL sch_found: got %b required 1", found); end
        if (found_key !== 24'd5)   begin failures++; $display("FAIL sch_found_key: got %0d required 5", found_key); end
        if (core_start !== '0)     begin failures++; $display("FAIL sch_no_dispatch: core_start=%b required 0", core_start); end
        man_pulse(4'b0001, 4'b0001);
        checks += 2;
        if (found_key !== 24'd5)   begin failures++; $display("FAIL sch_drain_hit: found_key=%0d required 5", found_key); end
        if (keys_tried !== 25'd7)  begin failures++; $display("FAIL sch_tried7: got %0d required 7", keys_tried); end
        man_pulse(4'b0010, 4'b0010);
        checks++;
        if (keys_tried !== 25'd7)  begin failures++; $display("FAIL sch_idle_finish: keys_tried=%0d required 7", keys_tried); end
        man_pulse(4'b0100, 4'b0000);
        @(negedge clk);
        checks += 3;
        if (finish !== 1'b1)       begin failures++; $display("FAIL sch_done: finish=%b required 1", finish); end
        if (keys_tried !== 25'd8)  begin failures++; $display("FAIL sch_tried8: got %0d required 8", keys_tried); end
        if (found_key !== 24'd5)   begin failures++; $display("FAIL sch_final_key: got %0d required 5", found_key); end
        while (rd_idx < obs_key.size()) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++; $display("FAIL sch_sb_key: issued %0d with nothing expected", obs_key[rd_idx]);
            end else begin
                if (obs_key[rd_idx] !== exp_q[0]) begin failures++; $display("FAIL sch_sb_key: issued %0d required %0d", obs_key[rd_idx], exp_q[0]); end
                void'(exp_q.pop_front());
            end
            rd_idx++;
        end
        checks++;
        if (exp_q.size() != 8) begin failures++; $display("FAIL sch_issued: %0d keys left required 8", exp_q.size()); end
        $display("test_same_cycle_hits: found_key=%0d keys_tried=%0d", found_key, keys_tried);
    endtask

    task automatic test_back_to_back();
        begin_run();
        wait_issued(4);
        man_pulse(4'b0100, '0);
        checks++;
        if (core_start !== 4'b0100 || core_key[2*KW +: KW] !== 24'd4) begin
            failures++; $display("FAIL b2b_same_core: core_start=%b key=%0d required 0100 key 4", core_start, core_key[2*KW +: KW]);
        end
        man_pulse(4'b0101, '0);
        checks++;
        if (core_start !== 4'b0001 || core_key[0 +: KW] !== 24'd5) begin
            failures++; $display("FAIL b2b_lowest_first: core_start=%b key=%0d required 0001 key 5", core_start, core_key[0 +: KW]);
        end
        @(negedge clk);
        checks += 2;
        if (core_start !== 4'b0100 || core_key[2*KW +: KW] !== 24'd6) begin
            failures++; $display("FAIL b2b_next_cycle: core_start=%b key=%0d required 0100 key 6", core_start, core_key[2*KW +: KW]);
        end
        if (keys_tried !== 25'd3) begin failures++; $display("FAIL b2b_tried: got %0d required 3", keys_tried); end
        @(negedge clk);
        while (rd_idx < obs_key.size()) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++; $display("FAIL b2b_sb_key: issued %0d with nothing expected", obs_key[rd_idx]);
            end else begin
                if (obs_key[rd_idx] !== exp_q[0]) begin failures++; $display("FAIL b2b_sb_key: issued %0d required %0d", obs_key[rd_idx], exp_q[0]); end
                void'(exp_q.pop_front());
            end
            rd_idx++;
        end
        checks++;
        if (exp_q.size() != 9) begin failures++; $display("FAIL b2b_issued: %0d keys left required 9", exp_q.size()); end
        $display("test_back_to_back: issued=%0d keys_tried=%0d", obs_key.size() - base, keys_tried);
    endtask

    task automatic test_reset_mid_run();
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks += 7;
        if (core_start !== '0) begin failures++; $display("FAIL mid_core_start: got %b required 0", core_start); end
        if (core_key !== '0)   begin failures++; $display("FAIL mid_core_key: got %h required 0", core_key); end
        if (busy !== 1'b0)     begin failures++; $display("FAIL mid_busy: got %b required 0", busy); end
        if (finish !== 1'b0)   begin failures++; $display("FAIL mid_finish: got %b required 0", finish); end
        if (found !== 1'b0)    begin failures++; $display("FAIL mid_found: got %b required 0", found); end
        if (found_key !== '0)  begin failures++; $display("FAIL mid_found_key: got %h required 0", found_key); end
        if (keys_tried !== '0) begin failures++; $display("FAIL mid_keys_tried: got %0d required 0", keys_tried); end
        @(negedge clk);
        reset     = 1'b0;
        auto_mode = 1'b1;
        for (int i = 0; i < NC; i++) lat[i] = 3;
        hit_a = 25'd2;
        hit_b = NO_HIT;
        begin_run();
        wait_done();
        while (rd_idx < obs_key.size()) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++; $display("FAIL rst_sb_key: issued %0d with nothing expected", obs_key[rd_idx]);
            end else begin
                if (obs_key[rd_idx] !== exp_q[0]) begin failures++; $display("FAIL rst_sb_key: issued %0d required %0d", obs_key[rd_idx], exp_q[0]); end
                void'(exp_q.pop_front());
            end
            rd_idx++;
        end
        checks += 4;
        if (exp_q.size() != 10)   begin failures++; $display("FAIL rst_issued: %0d keys left required 10", exp_q.size()); end
        if (found !== 1'b1)       begin failures++; $display("FAIL rst_found: got %b required 1", found); end
        if (found_key !== 24'd2)  begin failures++; $display("FAIL rst_found_key: got %0d required 2", found_key); end
        if (keys_tried !== 25'd6) begin failures++; $display("FAIL rst_keys_tried: got %0d required 6", keys_tried); end
        $display("test_reset_mid_run: restart found_key=%0d keys_tried=%0d", found_key, keys_tried);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        reset       = 1'b1;
        start       = 1'b0;
        auto_mode   = 1'b1;
        man_finish  = '0;
        man_found   = '0;
        model_flush = 1'b0;
        hit_a       = NO_HIT;
        hit_b       = NO_HIT;
        for (int i = 0; i < NC; i++) lat[i] = 10;
        test_reset();
        test_first_hit();
        test_exhaust_and_restarts();
        test_same_cycle_hits();
        test_back_to_back();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
